// File: rtl/rf_access_arbiter.sv
// Shares the register-file write port and rs2 read port between the core and a debug requester.
// Debug writes use idle write-port cycles; reads and starved writes stall the core for one cycle.
module rf_access_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_reg_write,
    input  logic [ADDR_W-1:0] core_rd_sel,
    input  logic [DATA_W-1:0] core_wb_data,
    input  logic [ADDR_W-1:0] core_rs2_sel,
    output logic              core_stall,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              rf_reg_write,
    output logic [ADDR_W-1:0] rf_rd_sel,
    output logic [DATA_W-1:0] rf_wb_data,
    output logic [ADDR_W-1:0] rf_rs2_sel,
    input  logic [DATA_W-1:0] rf_rs2_data
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] WAIT_SAT  = CW'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        STALL = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              lat_we_q, lat_we_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
    logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

    logic dbg_wr_port;

    // Gating with reset keeps the grant quiet while the block is held in reset.
    assign dbg_gnt    = reset && (state_q == IDLE) && dbg_req;
    assign core_stall = (state_q == STALL);
    assign dbg_rvalid = (state_q == RESP);
    assign dbg_rdata  = dbg_rdata_q;

    assign dbg_wr_port = lat_we_q &&
        ((state_q == STALL) || ((state_q == PEND) && !core_reg_write));

    always_comb begin
        rf_reg_write = core_reg_write;
        rf_rd_sel    = core_rd_sel;
        rf_wb_data   = core_wb_data;
        rf_rs2_sel   = core_rs2_sel;
        if (dbg_wr_port) begin
            rf_reg_write = (lat_addr_q != '0);
            rf_rd_sel    = lat_addr_q;
            rf_wb_data   = lat_wdata_q;
        end else if (state_q == STALL) begin
            rf_reg_write = 1'b0;
            rf_rs2_sel   = lat_addr_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        lat_we_d    = lat_we_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        dbg_rdata_d = dbg_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (dbg_req) begin
                    lat_we_d    = dbg_we;
                    lat_addr_d  = dbg_addr;
                    lat_wdata_d = dbg_wdata;
                    wait_cnt_d  = '0;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (!lat_we_q) begin
                    state_d = STALL;
                end else if (!core_reg_write) begin
                    dbg_rdata_d = lat_wdata_q;
                    state_d     = RESP;
                end else begin
                    if (wait_cnt_q != WAIT_SAT)
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WAIT_LAST)
                        state_d = STALL;
                end
            end
            STALL: begin
                dbg_rdata_d = lat_we_q ? lat_wdata_q : rf_rs2_data;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            lat_we_q    <= lat_we_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural register file behind it.
module tb_rf_access_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_reg_write;
    logic [4:0]  core_rd_sel;
    logic [31:0] core_wb_data;
    logic [4:0]  core_rs2_sel;
    logic        core_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic        dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        rf_reg_write;
    logic [4:0]  rf_rd_sel;
    logic [31:0] rf_wb_data;
    logic [4:0]  rf_rs2_sel;
    logic [31:0] rf_rs2_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] regs [32];

    always #5 clk = ~clk;

    rf_access_arbiter #(.DATA_W(32), .ADDR_W(5), .MAX_WAIT(4)) dut (
        .clk(clk),
        .reset(reset),
        .core_reg_write(core_reg_write),
        .core_rd_sel(core_rd_sel),
        .core_wb_data(core_wb_data),
        .core_rs2_sel(core_rs2_sel),
        .core_stall(core_stall),
        .dbg_req(dbg_req),
        .dbg_we(dbg_we),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .rf_reg_write(rf_reg_write),
        .rf_rd_sel(rf_rd_sel),
        .rf_wb_data(rf_wb_data),
        .rf_rs2_sel(rf_rs2_sel),
        .rf_rs2_data(rf_rs2_data)
    );

    // Register file: x0 hard-wired to zero.
    always @(posedge clk)
        if (rf_reg_write && rf_rd_sel != 5'd0)
            regs[rf_rd_sel] <= rf_wb_data;
    assign rf_rs2_data = (rf_rs2_sel == 5'd0) ? 32'd0 : regs[rf_rs2_sel];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'd0;
        reset = 1'b0;
        core_reg_write = 1'b1;
        core_rd_sel = 5'd9;
        core_wb_data = 32'h55;
        core_rs2_sel = 5'd4;
        dbg_req = 1'b1;
        dbg_we = 1'b1;
        dbg_addr = 5'd2;
        dbg_wdata = 32'h77;

        // 1: reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            step(); #1;
            chk("rst_gnt", 32'(dbg_gnt), 32'd0);
            chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
            chk("rst_stall", 32'(core_stall), 32'd0);
        end
        chk("rst_rf_we", 32'(rf_reg_write), 32'd1);
        chk("rst_rf_rd", 32'(rf_rd_sel), 32'd9);
        chk("rst_rf_wd", rf_wb_data, 32'h55);
        chk("rst_rf_rs2", 32'(rf_rs2_sel), 32'd4);
        chk("rst_rdata", dbg_rdata, 32'd0);

        step();
        reset = 1'b1;
        dbg_req = 1'b0;
        core_reg_write = 1'b0;

        // 2: write x5 on an idle port
        step();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd5; dbg_wdata = 32'hDEADBEEF;
        #1 chk("w5_gnt", 32'(dbg_gnt), 32'd1);
        chk("w5_stall0", 32'(core_stall), 32'd0);
        step();
        dbg_req = 1'b0;
        #1 chk("w5_gnt_off", 32'(dbg_gnt), 32'd0);
        chk("w5_rf_we", 32'(rf_reg_write), 32'd1);
        chk("w5_rf_rd", 32'(rf_rd_sel), 32'd5);
        chk("w5_rf_wd", rf_wb_data, 32'hDEADBEEF);
        chk("w5_stall1", 32'(core_stall), 32'd0);
        chk("w5_rv_early", 32'(dbg_rvalid), 32'd0);
        step(); #1;
        chk("w5_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("w5_rdata", dbg_rdata, 32'hDEADBEEF);
        chk("w5_stall2", 32'(core_stall), 32'd0);
        step();
        core_rs2_sel = 5'd5;
        #1 chk("w5_rv_off", 32'(dbg_rvalid), 32'd0);
        chk("w5_read", rf_rs2_data, 32'hDEADBEEF);

        // 3: write x7 while the core holds the write port
        step();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'h1234;
        core_reg_write = 1'b1; core_rd_sel = 5'd20; core_wb_data = 32'h99;
        #1 chk("w7_gnt", 32'(dbg_gnt), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            dbg_req = 1'b0;
            core_rd_sel = 5'(10 + i);
            core_wb_data = 32'h100 + 32'(i);
            #1 chk("w7_core_we", 32'(rf_reg_write), 32'd1);
            chk("w7_core_rd", 32'(rf_rd_sel), 32'(10 + i));
            chk("w7_nostall", 32'(core_stall), 32'd0);
        end
        step(); #1;
        chk("w7_stall", 32'(core_stall), 32'd1);
        chk("w7_rf_we", 32'(rf_reg_write), 32'd1);
        chk("w7_rf_rd", 32'(rf_rd_sel), 32'd7);
        chk("w7_rf_wd", rf_wb_data, 32'h1234);
        step(); #1;
        chk("w7_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("w7_rdata", dbg_rdata, 32'h1234);
        chk("w7_stall_off", 32'(core_stall), 32'd0);
        core_reg_write = 1'b0;
        step();
        core_rs2_sel = 5'd7;
        #1 chk("w7_read", rf_rs2_data, 32'h1234);
        core_rs2_sel = 5'd13;
        #1 chk("w7_core_last", rf_rs2_data, 32'h103);

        // 4: preload x3, then debug read
        step();
        core_reg_write = 1'b1; core_rd_sel = 5'd3; core_wb_data = 32'hA5A5A5A5;
        step();
        core_reg_write = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        core_rs2_sel = 5'd8;
        #1 chk("r3_gnt", 32'(dbg_gnt), 32'd1);
        step();
        dbg_req = 1'b0;
        #1 chk("r3_pend_stall", 32'(core_stall), 32'd0);
        step(); #1;
        chk("r3_stall", 32'(core_stall), 32'd1);
        chk("r3_rs2", 32'(rf_rs2_sel), 32'd3);
        chk("r3_no_we", 32'(rf_reg_write), 32'd0);
        step(); #1;
        chk("r3_stall_off", 32'(core_stall), 32'd0);
        chk("r3_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("r3_rdata", dbg_rdata, 32'hA5A5A5A5);
        chk("r3_rs2_back", 32'(rf_rs2_sel), 32'd8);
        step(); #1;
        chk("r3_rv_off", 32'(dbg_rvalid), 32'd0);
        chk("r3_hold", dbg_rdata, 32'hA5A5A5A5);

        // 5: write x0 is dropped but completes
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hFFFFFFFF;
        #1 chk("w0_gnt", 32'(dbg_gnt), 32'd1);
        step();
        dbg_req = 1'b0;
        #1 chk("w0_no_we", 32'(rf_reg_write), 32'd0);
        step(); #1;
        chk("w0_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("w0_rdata", dbg_rdata, 32'hFFFFFFFF);
        step();
        core_rs2_sel = 5'd0;
        #1 chk("w0_read", rf_rs2_data, 32'd0);

        // 6: reset during the stall of a read
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3;
        #1 chk("rr_gnt", 32'(dbg_gnt), 32'd1);
        step();
        dbg_req = 1'b0;
        step(); #1;
        chk("rr_stall", 32'(core_stall), 32'd1);
        #1 reset = 1'b0;
        #1 chk("rr_stall_drop", 32'(core_stall), 32'd0);
        chk("rr_rv_none", 32'(dbg_rvalid), 32'd0);
        step();
        reset = 1'b1;
        #1 chk("rr_rv_after", 32'(dbg_rvalid), 32'd0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd5;
        #1 chk("rr_regnt", 32'(dbg_gnt), 32'd1);
        step();
        dbg_req = 1'b0;
        step(); #1;
        chk("rr_stall2", 32'(core_stall), 32'd1);
        step(); #1;
        chk("rr_rvalid", 32'(dbg_rvalid), 32'd1);
        chk("rr_rdata", dbg_rdata, 32'hDEADBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
